inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage for the in-order RV32I core. It assembles 32-bit instructions from the byte-wide memory port and queries the branch predictor for conditional branches. It holds the fetched instruction and its prediction for the decode stage, and redirects on flushes from execute. It sits directly upstream of the predictor and decode stages and drives the predictor's query ports.

## Interface
Parameters:
- RESET_PC, 32'h0, first fetch address after reset

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- mem_req  out  1  byte read request
- mem_addr  out  32  byte address of the request
- mem_gnt  in  1  request accepted this cycle
- mem_rdata  in  8  byte for the grant of the previous cycle
- get_predict  out  1  predictor query strobe
- now_pc  out  32  PC of the queried instruction
- now_branch_inst  out  32  queried instruction word
- jump_predict  in  1  predictor taken flag, combinational, same cycle
- predict_pc  in  32  predicted next PC, combinational, same cycle
- ex_flush  in  1  misprediction redirect from execute
- ex_target  in  32  correct PC on ex_flush
- id_ready  in  1  decode accepts this cycle
- if_valid  out  1  instruction held for decode
- if_pc, if_inst  out  32 each  held PC and instruction
- if_pred_taken  out  1  prediction carried to execute
- if_pred_pc  out  32  predicted next PC carried to execute

## Operation
- States: FETCH and HOLD. Counters: iss_cnt (0..4, bytes granted) and rcv_cnt (0..4, bytes received). Registers: pc, buf[23:0], discard flag.
- FETCH:
  - mem_req = (iss_cnt<4) && !ex_flush.
  - mem_addr = pc + iss_cnt.
  - Each mem_req&&mem_gnt increments iss_cnt.
  - Each cycle after a grant, mem_rdata is stored little-endian in buf[8*rcv_cnt +: 8], and rcv_cnt increments.
- Final byte (rcv_cnt==3 with data arriving): inst = {mem_rdata, buf}.
  - If inst[6:0]==7'b1100011: get_predict=1, now_pc=pc, now_branch_inst=inst.
  - The same edge latches if_inst, if_pc, if_pred_taken=jump_predict and if_pred_pc=predict_pc.
  - For a non-branch: if_pred_taken=0, if_pred_pc=pc+4.
  - On that edge: pc←if_pred_pc, counters←0, if_valid←1, go to HOLD.
- HOLD:
  - No memory requests.
  - id_ready=1 → if_valid←0, go to FETCH. The next fetch request is issued in the following cycle.
- ex_flush (any state) has priority over every other event:
  - pc←ex_target, counters←0, if_valid←0, go to FETCH.
  - If a grant occurred in the flush cycle's predecessor, set discard. The next mem_rdata is then ignored and discard clears.
  - get_predict is forced to 0 in the flush cycle.
- When get_predict=0, now_pc and now_branch_inst are 0.
- Addresses wrap modulo 2^32. No alignment check.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, if_valid=0, if_inst=0, if_pc=0, if_pred_taken=0, if_pred_pc=0, counters 0, discard=0. mem_req asserts in the first cycle after reset release.
- Latency with continuous grants: 5 cycles from the first request to if_valid rising (grants at cycles 0–3, final byte at cycle 4, if_valid visible at cycle 5).
- Denied grants stall issue only. Bytes already granted still arrive on the next cycle.
- if_* outputs are stable while if_valid=1 and id_ready=0.
- ex_flush together with id_ready in HOLD: the flush wins and the instruction is dropped.
- ex_flush in the final-byte cycle: the instruction is dropped, with no prediction and no valid.
- Reset asserted mid-fetch: all state returns to reset values asynchronously.

## Configuration
- PREDICT_EN defined: behaviour as above.
- PREDICT_EN undefined:
  - get_predict is tied 0, and now_pc and now_branch_inst are tied 0.
  - jump_predict and predict_pc are ignored.
  - if_pred_taken=0, if_pred_pc=pc+4, and pc advances by 4 every instruction.

## Structure
- The shared defines package holds: opcode constant BRANCH_OP=7'b1100011, InstAddrBus, ZeroWord, and the FETCH/HOLD state encodings.
- Optional sub-module: fetch_byte_assembler, covering the counters, buf and discard logic.
- The top level keeps the FSM, PC and predictor interface.

## Test plan
- Reset released, memory returns 13 00 00 00 at 0..3 with grants every cycle → if_valid at cycle 5, if_inst=32'h00000013, if_pc=0, if_pred_pc=4, get_predict never high.
- Branch 32'hFE000EE3 at pc 8, predictor jump_predict=1, predict_pc=32'h4 → get_predict pulses once with now_pc=8; if_pred_taken=1; the next fetch starts at address 4.
- id_ready held 0 for 6 cycles → if_* constant and mem_req=0 throughout; id_ready=1 → if_valid drops, mem_req next cycle.
- ex_flush with ex_target=32'h100 after 2 grants → the byte following the flush is discarded and the next mem_addr is 32'h100, 0x101, ….
- mem_gnt alternating 0/1 → instruction assembled correctly, if_valid 9 cycles after the first request.
- PREDICT_EN undefined, branch fetched with jump_predict=1 → if_pred_taken=0, if_pred_pc=pc+4.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the RV32I instruction-fetch stage.
// Used by inst_fetch and fetch_byte_assembler.
package inst_fetch_pkg;

    localparam int InstAddrBus = 31;
    localparam logic [InstAddrBus:0] ZeroWord = 32'h0;
    localparam logic [6:0] BRANCH_OP = 7'b1100011;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    function automatic logic is_branch(input logic [31:0] inst);
        return inst[6:0] == BRANCH_OP;
    endfunction

endpackage

// File: rtl/inst_fetch_byte_assembler.sv
// Byte issue/receive counters and little-endian word assembly for fetch.
// A flush drops in-flight bytes; a late byte after a flush is discarded.
module fetch_byte_assembler
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_req,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rdata,
    output logic [2:0]  iss_cnt,
    output logic        last,
    output logic [31:0] word
);

    logic [2:0]  rcv_cnt;
    logic [23:0] byte_buf;
    logic        gnt_d;
    logic        discard;
    logic        issue;
    logic        arrive;

    assign issue  = mem_req && mem_gnt;
    assign arrive = gnt_d && !discard;
    assign last   = arrive && (rcv_cnt == 3'd3);
    assign word   = {mem_rdata, byte_buf};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_cnt  <= 3'd0;
            rcv_cnt  <= 3'd0;
            byte_buf <= 24'h0;
            gnt_d    <= 1'b0;
            discard  <= 1'b0;
        end else begin
            gnt_d   <= issue;
            // The byte granted just before a flush is stale.
            discard <= flush && gnt_d;
            if (flush || last) begin
                iss_cnt <= 3'd0;
                rcv_cnt <= 3'd0;
            end else begin
                if (issue) begin
                    iss_cnt <= iss_cnt + 3'd1;
                end
                if (arrive) begin
                    rcv_cnt <= rcv_cnt + 3'd1;
                    case (rcv_cnt[1:0])
                        2'd0:    byte_buf[7:0]   <= mem_rdata;
                        2'd1:    byte_buf[15:8]  <= mem_rdata;
                        2'd2:    byte_buf[23:16] <= mem_rdata;
                        default: byte_buf        <= byte_buf;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: FETCH/HOLD FSM, PC, predictor query, decode hold.
// Define PREDICT_EN to use the branch predictor; otherwise pc advances by 4.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rdata,
    output logic        get_predict,
    output logic [31:0] now_pc,
    output logic [31:0] now_branch_inst,
    input  logic        jump_predict,
    input  logic [31:0] predict_pc,
    input  logic        ex_flush,
    input  logic [31:0] ex_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_pc
);

    fetch_state_e state;
    fetch_state_e state_nxt;

    logic [InstAddrBus:0] pc;
    logic [2:0]           iss_cnt;
    logic                 last;
    logic [31:0]          word;
    logic                 take_pred;
    logic                 fetch_done;
    logic                 nxt_taken;
    logic [31:0]          nxt_pc;

    fetch_byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .flush     (ex_flush),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_rdata (mem_rdata),
        .iss_cnt   (iss_cnt),
        .last      (last),
        .word      (word)
    );

`ifdef PREDICT_EN
    assign take_pred = is_branch(word);
`else
    assign take_pred = 1'b0;
`endif

    assign fetch_done = (state == FETCH) && last && !ex_flush;
    assign nxt_taken  = take_pred ? jump_predict : 1'b0;
    assign nxt_pc     = take_pred ? predict_pc : pc + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: begin
                if (ex_flush) begin
                    state_nxt = FETCH;
                end else if (last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ex_flush || id_ready) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        mem_req         = 1'b0;
        mem_addr        = pc + {29'd0, iss_cnt};
        get_predict     = 1'b0;
        now_pc          = ZeroWord;
        now_branch_inst = ZeroWord;
        if (state == FETCH) begin
            mem_req = (iss_cnt < 3'd4) && !ex_flush;
        end
        if (fetch_done && take_pred) begin
            get_predict     = 1'b1;
            now_pc          = pc;
            now_branch_inst = word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc            <= RESET_PC;
            if_valid      <= 1'b0;
            if_pc         <= ZeroWord;
            if_inst       <= ZeroWord;
            if_pred_taken <= 1'b0;
            if_pred_pc    <= ZeroWord;
        end else if (ex_flush) begin
            pc       <= ex_target;
            if_valid <= 1'b0;
        end else if (fetch_done) begin
            pc            <= nxt_pc;
            if_valid      <= 1'b1;
            if_pc         <= pc;
            if_inst       <= word;
            if_pred_taken <= nxt_taken;
            if_pred_pc    <= nxt_pc;
        end else if (state == HOLD && id_ready) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a byte memory and a fixed predictor.
// Expectations follow PREDICT_EN when it is defined for the build.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

`ifdef PREDICT_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_rdata;
    logic        get_predict;
    logic [31:0] now_pc;
    logic [31:0] now_branch_inst;
    logic        jump_predict;
    logic [31:0] predict_pc;
    logic        ex_flush;
    logic [31:0] ex_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_pred_taken;
    logic [31:0] if_pred_pc;

    logic [7:0]  mem [0:511];
    int          n_tests;
    int          n_fail;
    int          gp_cnt;
    int          bad_zero;
    logic [31:0] gp_pc;
    logic [31:0] gp_inst;
    int          lat;

    inst_fetch #(.RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_gnt         (mem_gnt),
        .mem_rdata       (mem_rdata),
        .get_predict     (get_predict),
        .now_pc          (now_pc),
        .now_branch_inst (now_branch_inst),
        .jump_predict    (jump_predict),
        .predict_pc      (predict_pc),
        .ex_flush        (ex_flush),
        .ex_target       (ex_target),
        .id_ready        (id_ready),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_pred_taken   (if_pred_taken),
        .if_pred_pc      (if_pred_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put_word(input int addr, input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            mem[addr + b] = w[8*b +: 8];
        end
    endtask

    // One clock: drive inputs, sample the request, model the memory reply.
    task automatic step(input logic g, input logic r, input logic f,
                        input logic [31:0] t);
        logic        grant;
        logic [31:0] addr;
        mem_gnt   = g;
        id_ready  = r;
        ex_flush  = f;
        ex_target = t;
        #1;
        grant = mem_req && mem_gnt;
        addr  = mem_addr;
        if (get_predict) begin
            gp_cnt++;
            gp_pc   = now_pc;
            gp_inst = now_branch_inst;
        end else if (now_pc != 32'h0 || now_branch_inst != 32'h0) begin
            bad_zero++;
        end
        @(posedge clk);
        #1;
        mem_rdata = grant ? mem[addr[8:0]] : 8'hEE;
        ex_flush  = 1'b0;
        id_ready  = 1'b0;
        #1;
    endtask

    task automatic fetch_until_valid(input logic alt, output int n);
        n = -1;
        for (int i = 0; i < 30; i++) begin
            step(alt ? logic'(i % 2) : 1'b1, 1'b0, 1'b0, 32'h0);
            if (if_valid) begin
                n = i + 1;
                break;
            end
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        gp_cnt       = 0;
        bad_zero     = 0;
        gp_pc        = 32'h0;
        gp_inst      = 32'h0;
        rst          = 1'b0;
        mem_gnt      = 1'b0;
        mem_rdata    = 8'hEE;
        jump_predict = 1'b1;
        predict_pc   = 32'h4;
        ex_flush     = 1'b0;
        ex_target    = 32'h0;
        id_ready     = 1'b0;
        for (int a = 0; a < 512; a++) mem[a] = 8'h00;
        put_word(32'h000, 32'h00000013);
        put_word(32'h004, 32'h00100093);
        put_word(32'h008, 32'hFE000EE3);
        put_word(32'h100, 32'h00200093);
        put_word(32'h104, 32'h12345678);
        put_word(32'h1F0, 32'hFE000EE3);

        repeat (2) @(posedge clk);
        #1;
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_pred_pc", if_pred_pc, 32'h0);
        check("rst_if_taken", {31'd0, if_pred_taken}, 32'd0);
        rst = 1'b1;
        #1;
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h0);

        fetch_until_valid(1'b0, lat);
        check("nop_latency", lat, 32'd5);
        check("nop_inst", if_inst, 32'h00000013);
        check("nop_pc", if_pc, 32'h0);
        check("nop_pred_pc", if_pred_pc, 32'h4);
        check("nop_taken", {31'd0, if_pred_taken}, 32'd0);
        check("nop_no_predict", gp_cnt, 32'd0);

        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            check("hold_req", {31'd0, mem_req}, 32'd0);
            check("hold_valid", {31'd0, if_valid}, 32'd1);
            check("hold_inst", if_inst, 32'h00000013);
            check("hold_pred_pc", if_pred_pc, 32'h4);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("release_valid", {31'd0, if_valid}, 32'd0);
        check("release_req", {31'd0, mem_req}, 32'd1);
        check("release_addr", mem_addr, 32'h4);

        fetch_until_valid(1'b0, lat);
        check("addi_inst", if_inst, 32'h00100093);
        check("addi_taken", {31'd0, if_pred_taken}, 32'd0);
        check("addi_pred_pc", if_pred_pc, 32'h8);
        step(1'b1, 1'b1, 1'b0, 32'h0);

        fetch_until_valid(1'b0, lat);
        check("br_latency", lat, 32'd5);
        check("br_inst", if_inst, 32'hFE000EE3);
        check("br_pc", if_pc, 32'h8);
        check("br_gp_count", gp_cnt, PE ? 32'd1 : 32'd0);
        check("br_now_pc", gp_pc, PE ? 32'h8 : 32'h0);
        check("br_now_inst", gp_inst, PE ? 32'hFE000EE3 : 32'h0);
        check("br_taken", {31'd0, if_pred_taken}, PE ? 32'd1 : 32'd0);
        check("br_pred_pc", if_pred_pc, PE ? 32'h4 : 32'hC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("br_next_addr", mem_addr, PE ? 32'h4 : 32'hC);

        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h100);
        check("flush_valid", {31'd0, if_valid}, 32'd0);
        check("flush_addr0", mem_addr, 32'h100);
        check("flush_req", {31'd0, mem_req}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("flush_addr1", mem_addr, 32'h101);
        fetch_until_valid(1'b0, lat);
        check("flush_latency", lat, 32'd4);
        check("flush_inst", if_inst, 32'h00200093);
        check("flush_pc", if_pc, 32'h100);
        check("flush_pred_pc", if_pred_pc, 32'h104);
        step(1'b1, 1'b1, 1'b0, 32'h0);

        fetch_until_valid(1'b1, lat);
        check("alt_latency", lat, 32'd9);
        check("alt_inst", if_inst, 32'h12345678);
        check("alt_pc", if_pc, 32'h104);

        step(1'b1, 1'b1, 1'b1, 32'h1F0);
        check("flush_ready_valid", {31'd0, if_valid}, 32'd0);
        check("flush_ready_addr", mem_addr, 32'h1F0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h8);
        check("late_flush_valid", {31'd0, if_valid}, 32'd0);
        check("late_flush_gp", gp_cnt, PE ? 32'd1 : 32'd0);
        check("late_flush_addr", mem_addr, 32'h8);
        fetch_until_valid(1'b0, lat);
        check("refetch_latency", lat, 32'd5);
        check("refetch_pc", if_pc, 32'h8);
        check("refetch_gp", gp_cnt, PE ? 32'd2 : 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);

        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        check("arst_valid", {31'd0, if_valid}, 32'd0);
        check("arst_inst", if_inst, 32'h0);
        check("arst_pc", if_pc, 32'h0);
        check("arst_pred_pc", if_pred_pc, 32'h0);
        check("arst_addr", mem_addr, 32'h0);
        #3;
        rst       = 1'b1;
        mem_rdata = 8'hEE;
        #1;
        fetch_until_valid(1'b0, lat);
        check("arst_latency", lat, 32'd5);
        check("arst_refetch", if_inst, 32'h00000013);

        check("now_zero_idle", bad_zero, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
